mbus_arb: RTL and testbench

MBUS_ARB -- requirements
Module: mbus_arb

---
 rtl/mbus_arb.sv | 220 ++++++++++++++++++++++
 tb/tb_mbus_arb.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mbus_arb.sv
// Two-requester round-robin arbiter driving a SysAD/SysCmd processor bus.
// Optional read-response watchdog enabled by defining MBUS_ARB_TIMEOUT_EN.
module mbus_arb #(
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [1:0]  req,
   input  logic [1:0]  req_write,
   input  logic [1:0]  req_block,
   input  logic [3:0]  req_size,
   input  logic [63:0] req_addr,
   input  logic [63:0] req_wdata,
   output logic [1:0]  gnt,
   output logic        wdata_pop,
   output logic [31:0] rdata,
   output logic        rdata_valid,
   output logic        done,
   output logic        err,
   output logic        p_valid_l,
   output logic [31:0] sys_ad_out,
   output logic        sys_ad_oe,
   input  logic [31:0] sys_ad_in,
   output logic [4:0]  sys_cmd_out,
   input  logic [4:0]  sys_cmd_in,
   input  logic        e_ok_l,
   input  logic        e_valid_l
);

   typedef enum logic [1:0] {IDLE, CMD, WDATA, RDATA} state_t;

   state_t      state_q, state_d;
   logic [1:0]  gnt_q, gnt_d;
   logic        gidx_q, gidx_d;
   logic        last_q, last_d;
   logic        wr_q, wr_d;
   logic        blk_q, blk_d;
   logic [1:0]  size_q, size_d;
   logic [31:0] addr_q, addr_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        e_ok_l_d1_q, e_ok_l_d1_d;
   logic [31:0] rdata_q, rdata_d;
   logic        rvalid_q, rvalid_d;
   logic        done_q, done_d;
   logic        err_q, err_d;
   logic        sel_s;
   logic        cmd_cycle_s;
   logic [3:0]  unused_cmd_s;

`ifdef MBUS_ARB_TIMEOUT_EN
   localparam int TMO_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
   logic [TMO_W-1:0] tmo_q, tmo_d;
`else
   logic [31:0] unused_tmo_s;
   assign unused_tmo_s = 32'(TIMEOUT_CYCLES);
`endif

   // With both requesting, the requester not served last wins.
   assign sel_s        = (req == 2'b11) ? ~last_q : req[1];
   assign cmd_cycle_s  = (state_q == CMD) && !e_ok_l && !e_ok_l_d1_q;
   assign unused_cmd_s = {sys_cmd_in[4], sys_cmd_in[2:0]};

   // Next-state, transaction bookkeeping and bus drive.
   always_comb begin
      state_d     = state_q;
      gnt_d       = gnt_q;
      gidx_d      = gidx_q;
      last_d      = last_q;
      wr_d        = wr_q;
      blk_d       = blk_q;
      size_d      = size_q;
      addr_d      = addr_q;
      cnt_d       = cnt_q;
      e_ok_l_d1_d = 1'b1;
      rdata_d     = rdata_q;
      rvalid_d    = 1'b0;
      done_d      = 1'b0;
      err_d       = 1'b0;
`ifdef MBUS_ARB_TIMEOUT_EN
      tmo_d       = tmo_q;
`endif
      p_valid_l   = 1'b1;
      sys_ad_oe   = 1'b0;
      sys_ad_out  = 32'h0000_0000;
      sys_cmd_out = 5'b00000;
      wdata_pop   = 1'b0;

      case (state_q)
         IDLE: begin
            if (!done_q && (req != 2'b00)) begin
               gidx_d  = sel_s;
               gnt_d   = sel_s ? 2'b10 : 2'b01;
               wr_d    = req_write[sel_s];
               blk_d   = req_block[sel_s];
               size_d  = req_size[{sel_s, 1'b0} +: 2];
               addr_d  = req_addr[{sel_s, 5'd0} +: 32];
               state_d = CMD;
            end else begin
               state_d = IDLE;
            end
         end
         CMD: begin
            e_ok_l_d1_d = e_ok_l;
            if (cmd_cycle_s) begin
               p_valid_l   = 1'b0;
               sys_ad_oe   = 1'b1;
               sys_ad_out  = addr_q;
               sys_cmd_out = {1'b0, wr_q, blk_q, size_q};
               cnt_d       = blk_q ? (5'd2 << size_q) : 5'd1;
`ifdef MBUS_ARB_TIMEOUT_EN
               tmo_d       = '0;
`endif
               state_d     = wr_q ? WDATA : RDATA;
            end else begin
               state_d = CMD;
            end
         end
         WDATA: begin
            p_valid_l   = 1'b0;
            sys_ad_oe   = 1'b1;
            sys_ad_out  = req_wdata[{gidx_q, 5'd0} +: 32];
            wdata_pop   = 1'b1;
            sys_cmd_out = {1'b1, (cnt_q != 5'd1), 3'b000};
            cnt_d       = cnt_q - 5'd1;
            if (cnt_q == 5'd1) begin
               done_d  = 1'b1;
               gnt_d   = 2'b00;
               last_d  = gidx_q;
               state_d = IDLE;
            end else begin
               state_d = WDATA;
            end
         end
         RDATA: begin
            if (!e_valid_l) begin
               rdata_d  = sys_ad_in;
               rvalid_d = 1'b1;
`ifdef MBUS_ARB_TIMEOUT_EN
               tmo_d    = '0;
`endif
               if (!sys_cmd_in[3]) begin
                  done_d  = 1'b1;
                  gnt_d   = 2'b00;
                  last_d  = gidx_q;
                  state_d = IDLE;
               end else begin
                  state_d = RDATA;
               end
            end else begin
`ifdef MBUS_ARB_TIMEOUT_EN
               // Fires on the cycle that makes TIMEOUT_CYCLES silent cycles in a row.
               if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                  err_d   = 1'b1;
                  gnt_d   = 2'b00;
                  last_d  = gidx_q;
                  state_d = IDLE;
               end else begin
                  tmo_d   = tmo_q + 1'b1;
                  state_d = RDATA;
               end
`else
               state_d = RDATA;
`endif
            end
         end
         default: begin
            gnt_d   = 2'b00;
            state_d = IDLE;
         end
      endcase
   end

   // State and registered outputs with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         gnt_q       <= 2'b00;
         gidx_q      <= 1'b0;
         last_q      <= 1'b1;
         wr_q        <= 1'b0;
         blk_q       <= 1'b0;
         size_q      <= 2'b00;
         addr_q      <= 32'h0000_0000;
         cnt_q       <= 5'd0;
         e_ok_l_d1_q <= 1'b1;
         rdata_q     <= 32'h0000_0000;
         rvalid_q    <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
`ifdef MBUS_ARB_TIMEOUT_EN
         tmo_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         gnt_q       <= gnt_d;
         gidx_q      <= gidx_d;
         last_q      <= last_d;
         wr_q        <= wr_d;
         blk_q       <= blk_d;
         size_q      <= size_d;
         addr_q      <= addr_d;
         cnt_q       <= cnt_d;
         e_ok_l_d1_q <= e_ok_l_d1_d;
         rdata_q     <= rdata_d;
         rvalid_q    <= rvalid_d;
         done_q      <= done_d;
         err_q       <= err_d;
`ifdef MBUS_ARB_TIMEOUT_EN
         tmo_q       <= tmo_d;
`endif
      end
   end

   assign gnt         = gnt_q;
   assign rdata       = rdata_q;
   assign rdata_valid = rvalid_q;
   assign done        = done_q;
   assign err         = err_q;

endmodule

// File: tb/tb_mbus_arb.sv
// Directed bench for mbus_arb with a scoreboard queue of expected bus words and grants.
module tb_mbus_arb;

   logic        clock = 1'b0;
   logic        reset;
   logic [1:0]  req, req_write, req_block;
   logic [3:0]  req_size;
   logic [63:0] req_addr, req_wdata;
   logic [1:0]  gnt;
   logic        wdata_pop, rdata_valid, done, err, p_valid_l, sys_ad_oe;
   logic [31:0] rdata, sys_ad_out, sys_ad_in;
   logic [4:0]  sys_cmd_out, sys_cmd_in;
   logic        e_ok_l, e_valid_l;

   int          checks = 0;
   int          errors = 0;
   logic [63:0] exp_q[$];

   mbus_arb #(.TIMEOUT_CYCLES(256)) dut (
      .clock(clock), .reset(reset), .req(req), .req_write(req_write),
      .req_block(req_block), .req_size(req_size), .req_addr(req_addr),
      .req_wdata(req_wdata), .gnt(gnt), .wdata_pop(wdata_pop), .rdata(rdata),
      .rdata_valid(rdata_valid), .done(done), .err(err), .p_valid_l(p_valid_l),
      .sys_ad_out(sys_ad_out), .sys_ad_oe(sys_ad_oe), .sys_ad_in(sys_ad_in),
      .sys_cmd_out(sys_cmd_out), .sys_cmd_in(sys_cmd_in), .e_ok_l(e_ok_l),
      .e_valid_l(e_valid_l)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic sb_cmp(input string tag, input logic [63:0] obs);
      chk({tag, "_sb_nonempty"}, 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) chk(tag, obs, exp_q.pop_front());
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int dones;
      int cnt;
      logic [1:0] prev_gnt;
      logic [4:0] exp_cmd;

      reset = 1'b1; req = 2'b00; req_write = 2'b00; req_block = 2'b00; req_size = 4'h0;
      req_addr = 64'h0; req_wdata = 64'h0; sys_ad_in = 32'h0; sys_cmd_in = 5'b01000;
      e_ok_l = 1'b1; e_valid_l = 1'b1;
      tick(); tick(); settle();
      chk("rst_gnt", gnt, 2'b00);        chk("rst_pop", wdata_pop, 1'b0);
      chk("rst_rdata", rdata, 32'h0);    chk("rst_rvalid", rdata_valid, 1'b0);
      chk("rst_done", done, 1'b0);       chk("rst_err", err, 1'b0);
      chk("rst_pvl", p_valid_l, 1'b1);   chk("rst_oe", sys_ad_oe, 1'b0);
      chk("rst_ad", sys_ad_out, 32'h0);  chk("rst_cmd", sys_cmd_out, 5'b00000);
      reset = 1'b0;

      // Single word read from requester 0
      req = 2'b01; req_addr[31:0] = 32'h0400_0010; e_ok_l = 1'b0;
      tick(); settle();
      chk("t1_gnt", gnt, 2'b01); chk("t1_no_cmd_first", p_valid_l, 1'b1);
      req = 2'b00;
      tick(); settle();
      chk("t1_cmd_pvl", p_valid_l, 1'b0); chk("t1_cmd_oe", sys_ad_oe, 1'b1);
      chk("t1_cmd_ad", sys_ad_out, 32'h0400_0010); chk("t1_cmd", sys_cmd_out, 5'b00000);
      tick();
      e_valid_l = 1'b0; sys_ad_in = 32'hDEAD_BEEF; sys_cmd_in = 5'b00000;
      exp_q.push_back(64'hDEAD_BEEF);
      settle();
      chk("t1_rd_oe", sys_ad_oe, 1'b0); chk("t1_rd_pvl", p_valid_l, 1'b1);
      tick();
      e_valid_l = 1'b1; sys_cmd_in = 5'b01000; settle();
      chk("t1_rvalid", rdata_valid, 1'b1);
      if (rdata_valid) sb_cmp("t1_rdata", rdata);
      chk("t1_done", done, 1'b1); chk("t1_gnt_clr", gnt, 2'b00);
      tick(); settle();
      chk("t1_done_pulse", done, 1'b0); chk("t1_rvalid_pulse", rdata_valid, 1'b0);

      // Block write, size 1 (4 words), requester 1
      req = 2'b10; req_write = 2'b10; req_block = 2'b10; req_size = 4'b0100;
      req_addr[63:32] = 32'h0800_0100;
      tick(); settle();
      chk("t2_gnt", gnt, 2'b10);
      req = 2'b00;
      tick(); settle();
      chk("t2_cmd", sys_cmd_out, 5'b01101); chk("t2_cmd_ad", sys_ad_out, 32'h0800_0100);
      chk("t2_cmd_pvl", p_valid_l, 1'b0);
      tick();
      for (int k = 0; k < 4; k++) begin
         req_wdata[63:32] = 32'hA5A5_0000 + 32'(k);
         exp_q.push_back({32'h0, 32'hA5A5_0000 + 32'(k)});
         exp_cmd = {1'b1, (k != 3), 3'b000};
         settle();
         chk("t2_pvl", p_valid_l, 1'b0); chk("t2_pop", wdata_pop, 1'b1);
         chk("t2_oe", sys_ad_oe, 1'b1);  chk("t2_next", sys_cmd_out, exp_cmd);
         if (wdata_pop) sb_cmp("t2_wdata", sys_ad_out);
         tick();
      end
      settle();
      chk("t2_done", done, 1'b1); chk("t2_gnt_clr", gnt, 2'b00);
      chk("t2_pop_end", wdata_pop, 1'b0); chk("t2_pvl_end", p_valid_l, 1'b1);

      // Command withheld while e_ok_l high; also no grant in the done cycle
      req = 2'b01; req_write = 2'b00; req_block = 2'b00; req_addr[31:0] = 32'h0400_0020;
      e_ok_l = 1'b1;
      tick(); settle();
      chk("t3_no_gnt_after_done", gnt, 2'b00);
      tick(); settle();
      chk("t3_gnt", gnt, 2'b01);
      for (int i = 0; i < 5; i++) begin
         chk("t3_withheld", p_valid_l, 1'b1);
         tick(); settle();
      end
      e_ok_l = 1'b0; settle();
      chk("t3_first_low", p_valid_l, 1'b1);
      tick(); settle();
      chk("t3_cmd_pvl", p_valid_l, 1'b0); chk("t3_cmd_ad", sys_ad_out, 32'h0400_0020);
      req = 2'b00;
      tick();
      e_valid_l = 1'b0; sys_ad_in = 32'h1234_5678; sys_cmd_in = 5'b00000;
      exp_q.push_back(64'h1234_5678);
      tick();
      e_valid_l = 1'b1; sys_cmd_in = 5'b01000; settle();
      chk("t3_rvalid", rdata_valid, 1'b1);
      if (rdata_valid) sb_cmp("t3_rdata", rdata);
      chk("t3_done", done, 1'b1);
      tick();

      // Reset in the middle of a 16-word write
      req = 2'b01; req_write = 2'b01; req_block = 2'b01; req_size = 4'b0011;
      tick(); tick(); tick(); settle();
      chk("t5_pop0", wdata_pop, 1'b1);
      tick(); settle();
      chk("t5_pop1", wdata_pop, 1'b1); chk("t5_gnt", gnt, 2'b01);
      reset = 1'b1;
      tick(); settle();
      chk("t5_pvl", p_valid_l, 1'b1); chk("t5_gnt_clr", gnt, 2'b00);
      chk("t5_no_done", done, 1'b0);  chk("t5_no_pop", wdata_pop, 1'b0);
      reset = 1'b0; req = 2'b00;
      tick(); settle();
      chk("t5_no_done_after", done, 1'b0); chk("t5_no_err", err, 1'b0);

      // Round robin with both requesting across three word reads
      req = 2'b11; req_write = 2'b00; req_block = 2'b00;
      e_valid_l = 1'b0; sys_cmd_in = 5'b00000; sys_ad_in = 32'hCAFE_0000;
      exp_q.push_back(64'h1); exp_q.push_back(64'h2); exp_q.push_back(64'h1);
      prev_gnt = 2'b00; dones = 0;
      for (int c = 0; c < 60 && dones < 3; c++) begin
         tick(); settle();
         if (gnt != 2'b00 && prev_gnt == 2'b00) sb_cmp("t4_gnt", {62'h0, gnt});
         if (done) begin
            chk("t4_no_gnt_with_done", gnt, 2'b00);
            dones++;
         end
         prev_gnt = gnt;
      end
      req = 2'b00; e_valid_l = 1'b1; sys_cmd_in = 5'b01000;
      chk("t4_dones", dones, 3);
      tick(); tick();

`ifdef MBUS_ARB_TIMEOUT_EN
      // Silent slave: err exactly TIMEOUT_CYCLES after RDATA entry
      req = 2'b01; e_ok_l = 1'b0;
      tick(); tick(); req = 2'b00; tick();
      cnt = 0; settle();
      while (!err && cnt < 300) begin
         tick(); cnt++; settle();
         if (done) chk("t6_no_done", done, 1'b0);
      end
      chk("t6_err_latency", cnt, 256); chk("t6_gnt_clr", gnt, 2'b00);
      tick(); settle();
      chk("t6_err_pulse", err, 1'b0);
`else
      // Silent slave: transaction waits indefinitely, err stays low
      req = 2'b01; e_ok_l = 1'b0;
      tick(); tick(); req = 2'b00; tick();
      cnt = 0;
      for (int c = 0; c < 300; c++) begin
         tick(); settle();
         if (err || done || gnt != 2'b01) cnt++;
      end
      chk("t6_still_waiting", cnt, 0); chk("t6_gnt_held", gnt, 2'b01);
      reset = 1'b1; tick(); reset = 1'b0; settle();
      chk("t6_abort_gnt", gnt, 2'b00);
`endif

      chk("sb_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
